// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART bus addresses, receiver states and parity helper
package spart_pkg;

    localparam logic [1:0] SPART_ADDR_DATA = 2'b00;
    localparam logic [1:0] SPART_ADDR_STAT = 2'b01;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    // Expected parity bit for up to 9 data bits; unused upper bits must be zero
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/spart_sync_fifo.sv
// spart_sync_fifo: show-ahead synchronous FIFO, drops push when full, ignores pop when empty
module spart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A pop in the same cycle frees the slot a push into a full FIFO needs
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: oversampled SPART receiver with receive FIFO and sticky error flags
module spart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          rxd,
    input  logic                          iocs,
    input  logic                          iorw,
    input  logic [1:0]                    ioaddr,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rda,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun
);

    import spart_pkg::*;

    localparam int TW = $clog2(OVERSAMPLE);

    rx_state_t         state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_bad_q, par_bad_d, stop_bad_q, stop_bad_d;
    logic              rxd_s1_q, rxd_s2_q, rxd_s;
    logic              pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
    logic              done, mid, stop_fail, frame_ok, pop, push, clr, full, empty;
    logic [8:0]        par_in;

    assign rxd_s      = rxd_s2_q;
    assign rda        = ~empty;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;

    // Frame FSM: acts only on enable ticks, samples mid-bit, flags the final stop sample
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        done       = 1'b0;
        mid        = tick_q == '1;
        par_in     = '0;
        par_in[DATA_W-1:0] = shift_q;
        if (enable) begin
            case (state_q)
                IDLE: if (!rxd_s) begin
                    state_d    = START;
                    tick_d     = '0;
                    bit_d      = '0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                end
                START: if (tick_q == TW'(OVERSAMPLE/2 - 1)) begin
                    tick_d  = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
                DATA: begin
                    tick_d = tick_q + TW'(1);
                    if (mid) begin
                        shift_d = {rxd_s, shift_q[DATA_W-1:1]};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'(DATA_W - 1)) begin
                            bit_d   = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    tick_d = tick_q + TW'(1);
                    if (mid) begin
                        par_bad_d = rxd_s != calc_parity(par_in, PARITY_ODD != 0);
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    tick_d = tick_q + TW'(1);
                    if (mid) begin
                        stop_bad_d = stop_bad_q | ~rxd_s;
                        bit_d      = bit_q + 4'd1;
                        if (bit_q == 4'(STOP_BITS - 1)) begin
                            done    = 1'b1;
                            state_d = IDLE;
                            bit_d   = '0;
                            tick_d  = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Completion priority (framing, parity, overrun) and bus-driven pop/clear
    always_comb begin
        stop_fail = stop_bad_q | ~rxd_s;
        frame_ok  = done & ~stop_fail & ~par_bad_q;
        pop       = iocs & iorw & (ioaddr == SPART_ADDR_DATA) & ~empty;
        clr       = iocs & ~iorw & (ioaddr == SPART_ADDR_STAT);
        push      = frame_ok & (~full | pop);
        fe_d      = (done & stop_fail) | (fe_q & ~clr);
        pe_d      = (done & ~stop_fail & par_bad_q) | (pe_q & ~clr);
        ov_d      = (frame_ok & full & ~pop) | (ov_q & ~clr);
    end

    // Synchroniser, FSM and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ov_q       <= ov_d;
        end
    end

    spart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shift_q),
        .dout  (rx_data),
        .count (rx_count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_spart_rx_fifo.sv
// tb_spart_rx_fifo: scoreboard bench for an 8N1 receiver and an 8E2 receiver
module tb_spart_rx_fifo;

    logic       clk = 0, rst = 1, enable = 0;
    logic       rxd0 = 1, rxd1 = 1, iocs0 = 0, iocs1 = 0, iorw = 0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] rx_data0, rx_data1;
    logic       rda0, rda1, pe0, pe1, fe0, fe1, ov0, ov1;
    logic [2:0] cnt0, cnt1;
    logic [7:0] q0[$], q1[$];
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        enable = ~enable;
    end

    spart_rx_fifo u0 (
        .clk(clk), .rst(rst), .enable(enable), .rxd(rxd0), .iocs(iocs0), .iorw(iorw),
        .ioaddr(ioaddr), .rx_data(rx_data0), .rda(rda0), .rx_count(cnt0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0)
    );

    spart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .rxd(rxd1), .iocs(iocs1), .iorw(iorw),
        .ioaddr(ioaddr), .rx_data(rx_data1), .rda(rda1), .rx_count(cnt1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] flg(input int u);
        return (u == 0) ? {pe0, fe0, ov0} : {pe1, fe1, ov1};
    endfunction

    function automatic logic [2:0] cnt(input int u);
        return (u == 0) ? cnt0 : cnt1;
    endfunction

    task automatic ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!enable);
        end
        #1;
    endtask

    task automatic set_rxd(input int u, input logic v);
        if (u == 0) rxd0 = v; else rxd1 = v;
    endtask

    task automatic bus(input int u, input logic rw, input logic [1:0] a);
        if (u == 0) iocs0 = 1; else iocs1 = 1;
        iorw = rw;
        ioaddr = a;
        @(posedge clk);
        #1;
        iocs0 = 0;
        iocs1 = 0;
        iorw = 0;
        ioaddr = 2'b00;
    endtask

    task automatic pop_word(input int u);
        logic [7:0] e;
        e = 8'h00;
        if (u == 0 && q0.size() > 0) e = q0.pop_front();
        if (u == 1 && q1.size() > 0) e = q1.pop_front();
        check($sformatf("rda%0d_before_pop", u), (u == 0) ? rda0 : rda1, 1'b1);
        check($sformatf("pop%0d_data", u), (u == 0) ? rx_data0 : rx_data1, e);
        bus(u, 1'b1, 2'b00);
    endtask

    // Unit 0 frames are 8N1, unit 1 frames are 8 data + parity + 2 stops (sv[0] first)
    task automatic send(input int u, input logic [7:0] d, input logic pb, input logic [1:0] sv,
                        input bit pop_end);
        logic [11:0] b;
        int n;
        b = '0;
        for (int i = 0; i < 8; i++) b[1+i] = d[i];
        if (u == 1) begin
            b[9] = pb; b[10] = sv[0]; b[11] = sv[1]; n = 12;
        end else begin
            b[9] = sv[0]; n = 10;
        end
        ticks(1);
        for (int j = 0; j < n; j++) begin
            set_rxd(u, b[j]);
            if (j == n - 1 && pop_end) begin
                ticks(9);
                @(posedge clk);
                #1;
                pop_word(u);
                ticks(6);
            end else begin
                ticks(16);
            end
        end
        set_rxd(u, 1'b1);
        ticks(16);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        rst = 0;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst_data%0d", u), (u == 0) ? rx_data0 : rx_data1, 8'h00);
            check($sformatf("rst_rda%0d", u), (u == 0) ? rda0 : rda1, 1'b0);
            check($sformatf("rst_cnt%0d", u), cnt(u), 3'd0);
            check($sformatf("rst_flags%0d", u), flg(u), 3'b000);
        end

        q0.push_back(8'hAA);
        send(0, 8'hAA, 1'b0, 2'b01, 0);
        check("aa_rda", rda0, 1'b1);
        check("aa_cnt", cnt0, 3'd1);
        bus(0, 1'b0, 2'b00);
        bus(0, 1'b1, 2'b10);
        check("noop_cnt", cnt0, 3'd1);
        pop_word(0);
        check("aa_rda_after", rda0, 1'b0);
        check("aa_flags", flg(0), 3'b000);

        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) q0.push_back(8'(k));
            send(0, 8'(k), 1'b0, 2'b01, 0);
        end
        check("ovr_cnt", cnt0, 3'd4);
        check("ovr_flags", flg(0), 3'b001);
        for (int k = 0; k < 4; k++) pop_word(0);
        check("ovr_empty", rda0, 1'b0);
        bus(0, 1'b0, 2'b01);
        check("ovr_clear", flg(0), 3'b000);

        for (int k = 1; k <= 4; k++) begin
            q0.push_back(8'(k));
            send(0, 8'(k), 1'b0, 2'b01, 0);
        end
        q0.push_back(8'h05);
        send(0, 8'h05, 1'b0, 2'b01, 1);
        check("pp_flags", flg(0), 3'b000);
        check("pp_cnt", cnt0, 3'd4);
        for (int k = 0; k < 4; k++) pop_word(0);
        check("pp_cnt_end", cnt0, 3'd0);

        send(1, 8'h39, 1'b1, 2'b11, 0);
        check("par_flags", flg(1), 3'b100);
        check("par_cnt", cnt1, 3'd0);
        q1.push_back(8'h39);
        send(1, 8'h39, 1'b0, 2'b11, 0);
        check("par_ok_cnt", cnt1, 3'd1);
        pop_word(1);
        bus(1, 1'b0, 2'b01);
        check("par_clear", flg(1), 3'b000);

        send(0, 8'h55, 1'b0, 2'b00, 0);
        check("fe_flags0", flg(0), 3'b010);
        check("fe_cnt0", cnt0, 3'd0);
        bus(0, 1'b0, 2'b01);
        send(1, 8'h39, 1'b0, 2'b01, 0);
        check("fe_flags1", flg(1), 3'b010);
        check("fe_cnt1", cnt1, 3'd0);
        bus(1, 1'b0, 2'b01);
        send(1, 8'h39, 1'b1, 2'b01, 0);
        check("fe_prio", flg(1), 3'b010);
        bus(1, 1'b0, 2'b01);
        check("fe_clear", flg(1), 3'b000);

        ticks(1);
        rxd0 = 0;
        ticks(4);
        rxd0 = 1;
        ticks(40);
        check("glitch_cnt", cnt0, 3'd0);
        check("glitch_flags", flg(0), 3'b000);

        q0.push_back(8'h11);
        send(0, 8'h11, 1'b0, 2'b01, 0);
        check("pre_rst_cnt", cnt0, 3'd1);
        ticks(1);
        rxd0 = 0;
        ticks(16);
        for (int i = 0; i < 4; i++) begin
            rxd0 = i[0];
            ticks(16);
        end
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        rxd0 = 1;
        q0.delete();
        q1.delete();
        ticks(16 * 12);
        check("mid_rst_rda", rda0, 1'b0);
        check("mid_rst_cnt", cnt0, 3'd0);
        check("mid_rst_flags", flg(0), 3'b000);
        q0.push_back(8'hC3);
        send(0, 8'hC3, 1'b0, 2'b01, 0);
        check("c3_cnt", cnt0, 3'd1);
        pop_word(0);
        check("c3_flags", flg(0), 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
